// File: rtl/clk_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side programs the divisor and gates counting; the slave side reports the divided clock and strobes.
interface clk_div_prog_if #(
  parameter int WIDTH = 16
);
  logic             ena;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_pending;
  logic             div_ack;
  logic [WIDTH-1:0] cur_div;
  logic             clk_out;
  logic             tick_rise;
  logic             tick_fall;

  modport master (
    output ena, div_in, div_load,
    input  div_pending, div_ack, cur_div, clk_out, tick_rise, tick_fall
  );

  modport slave (
    input  ena, div_in, div_load,
    output div_pending, div_ack, cur_div, clk_out, tick_rise, tick_fall
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with registered clk_out and rise/fall strobes.
// A newly loaded divisor is held back until the current period wraps, so periods are never cut short.
module clk_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  clk_div_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(DEFAULT_DIV - 1);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cur_div_reg;
  logic [WIDTH-1:0] pending_reg;
  logic             div_pending_reg;
  logic             div_ack_reg;
  logic             clk_out_reg;
  logic             tick_rise_reg;
  logic             tick_fall_reg;

  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH:0]   half;
  logic             wrap;
  logic             apply;
  logic             is_one;

  always_comb begin
    // One extra bit so the maximum divisor cannot overflow when rounding up.
    half         = ({1'b0, cur_div_reg} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    wrap         = (cnt_reg == (cur_div_reg - ONE));
    apply        = wrap && div_pending_reg;
    cnt_next     = wrap ? '0 : (cnt_reg + ONE);
    is_one       = (cur_div_reg == ONE);
    pending_next = (bus.div_in == '0) ? ONE : bus.div_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg         <= CNT_RST;
      cur_div_reg     <= DIV_RST;
      pending_reg     <= DIV_RST;
      div_pending_reg <= 1'b0;
      div_ack_reg     <= 1'b0;
      clk_out_reg     <= 1'b0;
      tick_rise_reg   <= 1'b0;
      tick_fall_reg   <= 1'b0;
    end else begin
      if (bus.ena) begin
        // On an apply edge cnt_next is 0, which is always below any half, so clk_out rises.
        cnt_reg       <= cnt_next;
        clk_out_reg   <= ({1'b0, cnt_next} < half);
        tick_rise_reg <= wrap && (!clk_out_reg || is_one);
        tick_fall_reg <= ({1'b0, cnt_next} == half) && !is_one;
        div_ack_reg   <= apply;
        if (apply) begin
          cur_div_reg     <= pending_reg;
          div_pending_reg <= 1'b0;
        end
      end else begin
        tick_rise_reg <= 1'b0;
        tick_fall_reg <= 1'b0;
        div_ack_reg   <= 1'b0;
      end

      // A load on an apply edge is kept for the following wrap, hence it overrides the clear above.
      if (bus.div_load) begin
        pending_reg     <= pending_next;
        div_pending_reg <= 1'b1;
      end
    end
  end

  assign bus.div_pending = div_pending_reg;
  assign bus.div_ack     = div_ack_reg;
  assign bus.cur_div     = cur_div_reg;
  assign bus.clk_out     = clk_out_reg;
  assign bus.tick_rise   = tick_rise_reg;
  assign bus.tick_fall   = tick_fall_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed vectors push hand-computed expectations,
// a monitor pops and compares them after each clock edge or asynchronous reset.
module tb_clk_div_prog;

  localparam int WIDTH = 16;

  typedef struct {
    int               id;
    logic             clk_out;
    logic             rise;
    logic             fall;
    logic             ack;
    logic             pend;
    logic [WIDTH-1:0] cur;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   vec_id = 0;

  clk_div_prog_if #(.WIDTH(WIDTH)) bus ();

  clk_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle of stimulus and record what the outputs must be after its edge.
  task automatic cyc(input logic ena_v, input logic ld_v, input logic [WIDTH-1:0] din_v,
                     input logic c, input logic r, input logic f, input logic a,
                     input logic p, input logic [WIDTH-1:0] cur_v);
    exp_t e;
    @(negedge clk);
    bus.ena      = ena_v;
    bus.div_load = ld_v;
    bus.div_in   = din_v;
    e.id = vec_id; e.clk_out = c; e.rise = r; e.fall = f; e.ack = a; e.pend = p; e.cur = cur_v;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // Reset between clock edges; outputs must change without waiting for clk.
  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    bus.ena      = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    e.id = vec_id; e.clk_out = 1'b0; e.rise = 1'b0; e.fall = 1'b0; e.ack = 1'b0; e.pend = 1'b0; e.cur = 16'd4;
    exp_q.push_back(e);
    vec_id++;
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.clk_out !== e.clk_out || bus.tick_rise !== e.rise || bus.tick_fall !== e.fall ||
            bus.div_ack !== e.ack || bus.div_pending !== e.pend || bus.cur_div !== e.cur) begin
          fails++;
          $display("FAIL vec%0d got clk_out=%b rise=%b fall=%b ack=%b pend=%b cur=%0d want clk_out=%b rise=%b fall=%b ack=%b pend=%b cur=%0d",
                   e.id, bus.clk_out, bus.tick_rise, bus.tick_fall, bus.div_ack, bus.div_pending, bus.cur_div,
                   e.clk_out, e.rise, e.fall, e.ack, e.pend, e.cur);
        end
      end
    end
  end

  initial begin : stimulus
    bus.ena      = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held across a disabled edge
    cyc(0,0,0,  0,0,0,0,0,4);
    // Default divide-by-4: rise at edges 1,5,9; fall at 3,7
    cyc(1,0,0,  1,1,0,0,0,4);
    cyc(1,0,0,  1,0,0,0,0,4);
    cyc(1,0,0,  0,0,1,0,0,4);
    cyc(1,0,0,  0,0,0,0,0,4);
    cyc(1,0,0,  1,1,0,0,0,4);
    cyc(1,0,0,  1,0,0,0,0,4);
    cyc(1,0,0,  0,0,1,0,0,4);
    cyc(1,0,0,  0,0,0,0,0,4);
    cyc(1,0,0,  1,1,0,0,0,4);
    cyc(1,0,0,  1,0,0,0,0,4);
    // Load 7 then overwrite with 6 mid-period; old period completes, then 6 applies
    cyc(1,1,7,  0,0,1,0,1,4);
    cyc(1,1,6,  0,0,0,0,1,4);
    cyc(1,0,0,  1,1,0,1,0,6);
    cyc(1,0,0,  1,0,0,0,0,6);
    cyc(1,0,0,  1,0,0,0,0,6);
    cyc(1,0,0,  0,0,1,0,0,6);
    cyc(1,0,0,  0,0,0,0,0,6);
    cyc(1,0,0,  0,0,0,0,0,6);
    cyc(1,0,0,  1,1,0,0,0,6);
    // Freeze in the high phase for 3 cycles, with a load of 5 accepted while frozen
    cyc(0,0,0,  1,0,0,0,0,6);
    cyc(0,1,5,  1,0,0,0,1,6);
    cyc(0,0,0,  1,0,0,0,1,6);
    cyc(1,0,0,  1,0,0,0,1,6);
    cyc(1,0,0,  1,0,0,0,1,6);
    cyc(1,0,0,  0,0,1,0,1,6);
    cyc(1,0,0,  0,0,0,0,1,6);
    cyc(1,0,0,  0,0,0,0,1,6);
    cyc(1,0,0,  1,1,0,1,0,5);
    // Divide-by-5: high 3, low 2
    cyc(1,0,0,  1,0,0,0,0,5);
    cyc(1,0,0,  1,0,0,0,0,5);
    cyc(1,0,0,  0,0,1,0,0,5);
    cyc(1,0,0,  0,0,0,0,0,5);
    cyc(1,0,0,  1,1,0,0,0,5);
    cyc(1,0,0,  1,0,0,0,0,5);
    cyc(1,0,0,  1,0,0,0,0,5);
    cyc(1,0,0,  0,0,1,0,0,5);
    cyc(1,0,0,  0,0,0,0,0,5);
    // Load 1 on a wrap edge: captured, applied one full period later
    cyc(1,1,1,  1,1,0,0,1,5);
    cyc(1,0,0,  1,0,0,0,1,5);
    cyc(1,0,0,  1,0,0,0,1,5);
    cyc(1,0,0,  0,0,1,0,1,5);
    cyc(1,0,0,  0,0,0,0,1,5);
    cyc(1,0,0,  1,1,0,1,0,1);
    cyc(1,0,0,  1,1,0,0,0,1);
    cyc(1,0,0,  1,1,0,0,0,1);
    // Load 0 is stored as 1
    cyc(1,1,0,  1,1,0,0,1,1);
    cyc(1,0,0,  1,1,0,1,0,1);
    cyc(1,0,0,  1,1,0,0,0,1);
    // Divide-by-3: high 2, low 1
    cyc(1,1,3,  1,1,0,0,1,1);
    cyc(1,0,0,  1,1,0,1,0,3);
    cyc(1,0,0,  1,0,0,0,0,3);
    cyc(1,0,0,  0,0,1,0,0,3);
    cyc(1,0,0,  1,1,0,0,0,3);
    cyc(1,1,7,  1,0,0,0,1,3);
    // Mid-period reset with a load pending; 7 must never take effect
    async_reset();
    cyc(1,0,0,  1,1,0,0,0,4);
    cyc(1,0,0,  1,0,0,0,0,4);
    cyc(1,0,0,  0,0,1,0,0,4);
    cyc(1,0,0,  0,0,0,0,0,4);
    cyc(1,0,0,  1,1,0,0,0,4);
    cyc(1,0,0,  1,0,0,0,0,4);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d unchecked entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
